i2c_slave: RTL

Target-side I2C engine that sits on the same SDA/SCL bus as the team's I2C master and answers it. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and then either receives write bytes or returns read bytes. Byte handshakes go to user logic; SDA is driven open-drain.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_line_sync.sv | 43 ++++
 rtl/i2c_slave.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: the protocol state encoding used by the slave
// engine and, later, by the master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings the asynchronous SCL/SDA lines into the clk domain and derives
// single-cycle SCL edge and START/STOP condition strobes.
module i2c_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  input  logic sda,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign scl_s     = scl_ff[1];
  assign sda_s     = sda_ff[1];
  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target engine: address match, byte receive/transmit with ACK
// handling, and an open-drain SDA driver.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         ACK_HOLD   = 300
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       tx_req,
  output logic       tx_done,
  output logic       busy,
  output logic       rw
);

  localparam int HOLD_W = $clog2(ACK_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACK_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(ACK_HOLD);

  i2c_state_e        state_q, state_d;
  logic [3:0]        bit_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [7:0]        shreg;
  logic              drive_q, drive_d;
  logic              ack_q, ack_d;
  logic              busy_d, rw_d;
  logic              rx_done_d, tx_req_d, tx_done_d;
  logic              shift_in, shift_out, load_tx, rx_load;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic hold_done, addr_match;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl       (scl),
    .sda       (sda),
    .scl_s     (scl_s),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sda = drive_q ? 1'b0 : 1'bz;

  // Releasing the ACK only while SCL is low keeps our own edge from reading as STOP.
  assign hold_done  = (hold_cnt >= HOLD_LAST) && !scl_s;
  assign addr_match = (shreg[7:1] == SLAVE_ADDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR:     if (scl_fall && bit_cnt == 4'd8) state_d = addr_match ? ADDR_ACK : IDLE;
        ADDR_ACK: if (hold_done) state_d = rw ? TX : RX;
        RX:       if (scl_fall && bit_cnt == 4'd8) state_d = RX_ACK;
        RX_ACK:   if (hold_done) state_d = RX;
        TX:       if (scl_fall && bit_cnt == 4'd7) state_d = TX_ACK;
        TX_ACK: begin
          if (scl_rise && sda_s)      state_d = WAIT;
          else if (scl_fall && ack_q) state_d = TX;
        end
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    drive_d   = drive_q;
    ack_d     = ack_q;
    busy_d    = busy;
    rw_d      = rw;
    rx_done_d = 1'b0;
    tx_req_d  = 1'b0;
    tx_done_d = 1'b0;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    load_tx   = 1'b0;
    rx_load   = 1'b0;
    if (start_det) begin
      drive_d = 1'b0;
      ack_d   = 1'b0;
    end else if (stop_det) begin
      drive_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          shift_in = scl_rise && (bit_cnt < 4'd8);
          if (scl_fall && bit_cnt == 4'd8) begin
            if (addr_match) begin
              drive_d = 1'b1;
              busy_d  = 1'b1;
              rw_d    = shreg[0];
              if (shreg[0]) begin
                tx_req_d = 1'b1;
                load_tx  = 1'b1;
              end
            end else begin
              busy_d = 1'b0;
            end
          end
        end
        ADDR_ACK: if (hold_done) drive_d = rw ? ~shreg[7] : 1'b0;
        RX: begin
          shift_in = scl_rise && (bit_cnt < 4'd8);
          if (scl_fall && bit_cnt == 4'd8) begin
            rx_load   = 1'b1;
            rx_done_d = 1'b1;
            drive_d   = 1'b1;
          end
        end
        RX_ACK: if (hold_done) drive_d = 1'b0;
        TX: begin
          if (scl_fall) begin
            shift_out = 1'b1;
            drive_d   = (bit_cnt == 4'd7) ? 1'b0 : ~shreg[6];
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            tx_done_d = 1'b1;
            ack_d     = ~sda_s;
          end else if (scl_fall && ack_q) begin
            tx_req_d = 1'b1;
            load_tx  = 1'b1;
            drive_d  = ~tx_data[7];
            ack_d    = 1'b0;
          end
        end
        default: drive_d = 1'b0;
      endcase
    end
  end

  // Datapath: shift register, counters and registered strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      hold_cnt <= '0;
      shreg    <= '0;
      drive_q  <= 1'b0;
      ack_q    <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
      rx_data  <= 8'h00;
      rx_done  <= 1'b0;
      tx_req   <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      if (start_det || state_d != state_q) bit_cnt <= '0;
      else if (shift_in || shift_out)      bit_cnt <= bit_cnt + 4'd1;
      if (state_d != state_q)       hold_cnt <= '0;
      else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
      if (load_tx)        shreg <= tx_data;
      else if (shift_in)  shreg <= {shreg[6:0], sda_s};
      else if (shift_out) shreg <= {shreg[6:0], 1'b0};
      if (rx_load) rx_data <= shreg;
      drive_q <= drive_d;
      ack_q   <= ack_d;
      busy    <= busy_d;
      rw      <= rw_d;
      rx_done <= rx_done_d;
      tx_req  <= tx_req_d;
      tx_done <= tx_done_d;
    end
  end

endmodule
